// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer encodings and master FSM states shared by the master slice.
package ahb_pkg;
    typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_e;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} mst_state_e;
endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: burst address register, word increment, beat countdown and 1 KB restart detect.
module ahb_addr_gen #(
    parameter int LEN_W = 4,
    parameter bit SPLIT = 1'b0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             load,
    input  logic             adv,
    input  logic [31:0]      start_addr,
    input  logic [LEN_W-1:0] len,
    output logic [31:0]      addr,
    output logic             last,
    output logic             restart
);
    logic [LEN_W-1:0] cnt;
    logic [31:0] next_addr;
    assign next_addr = addr + 32'd4;
    assign last = (cnt == '0);
    // next beat lands on a 1 KB boundary, so the burst must be restarted with NONSEQ
    assign restart = SPLIT && (next_addr[9:0] == 10'd0);
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr <= '0;
            cnt <= '0;
        end else if (load) begin
            addr <= start_addr & 32'hFFFF_FFFC;
            cnt <= len;
        end else if (adv && !last) begin
            addr <= next_addr;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: command/write-stream to AHB-Lite SINGLE/INCR word transfers, read data returned as a stream.
// Define AHB_MASTER_1KB_SPLIT_EN to restart bursts with NONSEQ when crossing a 1 KB boundary.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             rd_last,
    input  logic             HREADY,
    input  logic [31:0]      HRDATA,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HBURST,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA
);
`ifdef AHB_MASTER_1KB_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    mst_state_e state, state_nx;
    htrans_e trans;
    logic ns, dp_act, dp_read, dp_last, accept, last, restart, load, rd_hit;
    assign cmd_ready = (state == IDLE);
    assign load = cmd_valid && cmd_ready;
    // a write beat without data parks the bus: IDLE before a (re)started burst, BUSY inside one
    assign trans = (state != XFER) ? TR_IDLE :
                   (HWRITE && !wr_valid) ? (ns ? TR_IDLE : TR_BUSY) :
                   (ns ? TR_NONSEQ : TR_SEQ);
    assign accept = HREADY && (trans == TR_NONSEQ || trans == TR_SEQ);
    assign wr_ready = accept && HWRITE;
    assign rd_hit = dp_act && dp_read && HREADY;
    assign HTRANS = trans;
    assign HSIZE = HSIZE_WORD;
    ahb_addr_gen #(.LEN_W(LEN_W), .SPLIT(SPLIT)) u_addr_gen (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .load(load),
        .adv(accept),
        .start_addr(cmd_addr),
        .len(cmd_len),
        .addr(HADDR),
        .last(last),
        .restart(restart)
    );
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE && cmd_valid) ? XFER :
                   (state == XFER && accept && last) ? DRAIN :
                   (state == DRAIN && HREADY) ? IDLE : state;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HWRITE <= 1'b0;
            HBURST <= HBURST_SINGLE;
            HWDATA <= '0;
            ns <= 1'b0;
            dp_act <= 1'b0;
            dp_read <= 1'b0;
            dp_last <= 1'b0;
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_valid <= rd_hit;
            rd_last <= rd_hit && dp_last;
            if (rd_hit) rd_data <= HRDATA;
            if (HREADY) begin
                dp_act <= accept;
                dp_read <= !HWRITE;
                dp_last <= last;
            end
            if (load) begin
                HWRITE <= cmd_write;
                HBURST <= (cmd_len != '0) ? HBURST_INCR : HBURST_SINGLE;
                ns <= 1'b1;
            end else if (accept) ns <= restart;
            if (wr_ready) HWDATA <= wr_data;
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed scenarios against a small AHB slave model with bus/read-stream loggers.
module tb_ahb_lite_master;
    logic HCLK, HRESETn, cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready;
    logic rd_valid, rd_last, HREADY, HWRITE;
    logic [31:0] cmd_addr, wr_data, rd_data, HRDATA, HADDR, HWDATA;
    logic [3:0] cmd_len;
    logic [1:0] HTRANS;
    logic [2:0] HBURST, HSIZE;
    int n_checks = 0, n_fail = 0;

    ahb_lite_master #(.LEN_W(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .HREADY(HREADY), .HRDATA(HRDATA), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HBURST(HBURST), .HSIZE(HSIZE), .HWDATA(HWDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // slave model: data-phase address tracking, write memory, read data = address ^ 0x5A5A0000
    logic dp_v, dp_w, clr, wr_en;
    logic [31:0] dp_a;
    logic [31:0] mem [0:255];
    assign HRDATA = dp_a ^ 32'h5A5A_0000;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_v <= 1'b0; dp_w <= 1'b0; dp_a <= '0;
        end else if (HREADY) begin
            if (dp_v && dp_w) mem[dp_a[9:2]] <= HWDATA;
            dp_v <= HTRANS[1]; dp_a <= HADDR; dp_w <= HWRITE;
        end
    end

    // write-data source
    logic [31:0] wdat [0:3];
    int wr_idx, wr_tot;
    assign wr_valid = wr_en && (wr_idx < wr_tot);
    assign wr_data = wdat[wr_idx[1:0]];
    always @(posedge HCLK) if (clr) wr_idx <= 0; else if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;

    // loggers: accepted address phases, BUSY cycles, idle gap before an accept, read beats
    logic [31:0] acc_a [0:15];
    logic [1:0] acc_t [0:15];
    logic [2:0] acc_b [0:15];
    logic [31:0] rd_d [0:15];
    logic rd_l [0:15];
    int acc_n, busy_n, idle_cnt, gap, rd_n;
    always @(posedge HCLK) begin
        if (clr) begin
            acc_n <= 0; busy_n <= 0; idle_cnt <= 0; gap <= 0; rd_n <= 0;
        end else begin
            if (HREADY && HTRANS[1] && acc_n < 16) begin
                acc_a[acc_n] <= HADDR; acc_t[acc_n] <= HTRANS; acc_b[acc_n] <= HBURST;
                acc_n <= acc_n + 1; gap <= idle_cnt; idle_cnt <= 0;
            end else if (HREADY && HTRANS == 2'b00) idle_cnt <= idle_cnt + 1;
            if (HREADY && HTRANS == 2'b01) busy_n <= busy_n + 1;
            if (rd_valid && rd_n < 16) begin
                rd_d[rd_n] <= rd_data; rd_l[rd_n] <= rd_last; rd_n <= rd_n + 1;
            end
        end
    end

    task automatic clear_logs();
        clr = 1'b1; @(posedge HCLK); @(negedge HCLK); clr = 1'b0;
    endtask

    // returns at the negedge after the command handshake
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [3:0] l);
        bit done = 0;
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (cmd_ready) begin
                @(posedge HCLK); @(negedge HCLK); done = 1;
            end else @(negedge HCLK);
        end
        cmd_valid = 1'b0;
        if (!done) begin
            n_checks++; n_fail++; $display("FAIL cmd_timeout: cmd_ready never seen, addr %h", a);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (cmd_ready) done = 1; else @(negedge HCLK);
        end
        if (!done) begin
            n_checks++; n_fail++; $display("FAIL idle_timeout: cmd_ready stayed low");
        end
        repeat (2) @(negedge HCLK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge HCLK);
        n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %h exp 0", HTRANS); end
        n_checks++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h exp 0", HADDR); end
        n_checks++; if ({HWRITE, HBURST} !== 4'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h exp 0", {HWRITE, HBURST}); end
        n_checks++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h exp 0", HWDATA); end
        n_checks++; if ({rd_valid, rd_last, wr_ready} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b exp 000", {rd_valid, rd_last, wr_ready}); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); end
        n_checks++; if (HSIZE !== 3'b010) begin n_fail++; $display("FAIL rst_hsize: got %h exp 2", HSIZE); end
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_single_write();
        clear_logs();
        wdat[0] = 32'hDEAD_BEEF; wr_tot = 1; wr_en = 1'b1;
        send_cmd(1'b1, 32'h8000_0010, 4'd0);
        n_checks++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL sw_c1_htrans: got %h exp 2", HTRANS); end
        n_checks++; if (HADDR !== 32'h8000_0010) begin n_fail++; $display("FAIL sw_c1_haddr: got %h exp 80000010", HADDR); end
        n_checks++; if ({HWRITE, HBURST} !== 4'b1000) begin n_fail++; $display("FAIL sw_c1_ctrl: got %b exp 1000", {HWRITE, HBURST}); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_c1_wr_ready: got %b exp 1", wr_ready); end
        @(negedge HCLK);
        n_checks++; if (HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_c2_hwdata: got %h exp deadbeef", HWDATA); end
        n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL sw_c2_htrans: got %h exp 0", HTRANS); end
        wait_idle();
        n_checks++; if (mem[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_mem4: got %h exp deadbeef", mem[4]); end
        n_checks++; if (acc_n !== 1) begin n_fail++; $display("FAIL sw_beats: got %0d exp 1", acc_n); end
        wr_en = 1'b0;
    endtask

    task automatic test_incr_read();
        logic [31:0] exp_d [4] = '{32'hDA5A_0000, 32'hDA5A_0004, 32'hDA5A_0008, 32'hDA5A_000C};
        logic [1:0] exp_t [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
        clear_logs();
        send_cmd(1'b0, 32'h8000_0000, 4'd3);
        wait_idle();
        n_checks++; if (acc_n !== 4) begin n_fail++; $display("FAIL rd_beats: got %0d exp 4", acc_n); end
        n_checks++; if (rd_n !== 4) begin n_fail++; $display("FAIL rd_returns: got %0d exp 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (acc_a[i] !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL rd_haddr[%0d]: got %h exp %h", i, acc_a[i], 32'h8000_0000 + 32'(4 * i)); end
            n_checks++; if (acc_t[i] !== exp_t[i]) begin n_fail++; $display("FAIL rd_htrans[%0d]: got %h exp %h", i, acc_t[i], exp_t[i]); end
            n_checks++; if (acc_b[i] !== 3'b001) begin n_fail++; $display("FAIL rd_hburst[%0d]: got %h exp 1", i, acc_b[i]); end
            n_checks++; if (rd_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL rd_data[%0d]: got %h exp %h", i, rd_d[i], exp_d[i]); end
            n_checks++; if (rd_l[i] !== (i == 3)) begin n_fail++; $display("FAIL rd_last[%0d]: got %b exp %b", i, rd_l[i], i == 3); end
        end
    endtask

    task automatic test_boundary();
`ifdef AHB_MASTER_1KB_SPLIT_EN
        logic [1:0] exp_t [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
`else
        logic [1:0] exp_t [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
`endif
        logic [31:0] exp_a [4] = '{32'h8000_03F8, 32'h8000_03FC, 32'h8000_0400, 32'h8000_0404};
        clear_logs();
        send_cmd(1'b0, 32'h8000_03F8, 4'd3);
        wait_idle();
        n_checks++; if (acc_n !== 4) begin n_fail++; $display("FAIL kb_beats: got %0d exp 4", acc_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (acc_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL kb_haddr[%0d]: got %h exp %h", i, acc_a[i], exp_a[i]); end
            n_checks++; if (acc_t[i] !== exp_t[i]) begin n_fail++; $display("FAIL kb_htrans[%0d]: got %h exp %h", i, acc_t[i], exp_t[i]); end
        end
        n_checks++; if (rd_n !== 4 || rd_l[3] !== 1'b1) begin n_fail++; $display("FAIL kb_reads: got %0d/%b exp 4/1", rd_n, rd_l[3]); end
    endtask

    task automatic test_hready_stall();
        logic [31:0] exp_d [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        clear_logs();
        for (int i = 0; i < 4; i++) wdat[i] = exp_d[i];
        wr_tot = 4; wr_en = 1'b1;
        send_cmd(1'b1, 32'h8000_0020, 4'd3);
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h8000_0020) begin n_fail++; $display("FAIL st_beat1: got %h/%h exp 2/80000020", HTRANS, HADDR); end
        @(negedge HCLK);
        HREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge HCLK);
            #1;
            n_checks++; if (HTRANS !== 2'b11 || HADDR !== 32'h8000_0024) begin n_fail++; $display("FAIL st_hold_addr[%0d]: got %h/%h exp 3/80000024", c, HTRANS, HADDR); end
            n_checks++; if (HWDATA !== exp_d[0] || HWRITE !== 1'b1) begin n_fail++; $display("FAIL st_hold_data[%0d]: got %h/%b exp %h/1", c, HWDATA, HWRITE, exp_d[0]); end
            n_checks++; if (wr_ready !== 1'b0 || wr_idx !== 1) begin n_fail++; $display("FAIL st_wr_ready[%0d]: got %b/%0d exp 0/1", c, wr_ready, wr_idx); end
        end
        HREADY = 1'b1;
        wait_idle();
        n_checks++; if (wr_idx !== 4) begin n_fail++; $display("FAIL st_wr_pulses: got %0d exp 4", wr_idx); end
        n_checks++; if (acc_n !== 4) begin n_fail++; $display("FAIL st_beats: got %0d exp 4", acc_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem[8 + i] !== exp_d[i]) begin n_fail++; $display("FAIL st_mem[%0d]: got %h exp %h", 8 + i, mem[8 + i], exp_d[i]); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_busy();
        logic [31:0] exp_d [4] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
        logic [1:0] exp_t [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
        clear_logs();
        for (int i = 0; i < 4; i++) wdat[i] = exp_d[i];
        wr_tot = 4; wr_en = 1'b1;
        send_cmd(1'b1, 32'h8000_0040, 4'd3);
        @(negedge HCLK);
        wr_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge HCLK);
            #1;
            n_checks++; if (HTRANS !== 2'b01 || HADDR !== 32'h8000_0044) begin n_fail++; $display("FAIL bz_busy[%0d]: got %h/%h exp 1/80000044", c, HTRANS, HADDR); end
        end
        wr_en = 1'b1;
        #1;
        n_checks++; if (HTRANS !== 2'b11 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL bz_resume: got %h/%b exp 3/1", HTRANS, wr_ready); end
        wait_idle();
        n_checks++; if (busy_n !== 3) begin n_fail++; $display("FAIL bz_busy_cycles: got %0d exp 3", busy_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (acc_t[i] !== exp_t[i] || acc_a[i] !== 32'h8000_0040 + 32'(4 * i)) begin n_fail++; $display("FAIL bz_beat[%0d]: got %h/%h exp %h/%h", i, acc_t[i], acc_a[i], exp_t[i], 32'h8000_0040 + 32'(4 * i)); end
            n_checks++; if (mem[16 + i] !== exp_d[i]) begin n_fail++; $display("FAIL bz_mem[%0d]: got %h exp %h", 16 + i, mem[16 + i], exp_d[i]); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_cmd(1'b0, 32'h8000_0200, 4'd0);
        send_cmd(1'b0, 32'h8000_0204, 4'd0);
        wait_idle();
        n_checks++; if (rd_n !== 2) begin n_fail++; $display("FAIL b2b_returns: got %0d exp 2", rd_n); end
        n_checks++; if (rd_d[0] !== 32'hDA5A_0200 || rd_d[1] !== 32'hDA5A_0204) begin n_fail++; $display("FAIL b2b_data: got %h %h exp da5a0200 da5a0204", rd_d[0], rd_d[1]); end
        n_checks++; if (rd_l[0] !== 1'b1 || rd_l[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got %b%b exp 11", rd_l[0], rd_l[1]); end
        n_checks++; if (gap < 1) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d exp >=1", gap); end
        n_checks++; if (acc_b[0] !== 3'b000) begin n_fail++; $display("FAIL b2b_hburst: got %h exp 0", acc_b[0]); end
    endtask

    task automatic test_reset_mid_burst();
        clear_logs();
        send_cmd(1'b0, 32'h8000_0080, 4'd3);
        @(negedge HCLK);
        n_checks++; if (HTRANS !== 2'b11 || HADDR !== 32'h8000_0084) begin n_fail++; $display("FAIL mr_beat2: got %h/%h exp 3/80000084", HTRANS, HADDR); end
        HRESETn = 1'b0;
        #1;
        n_checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin n_fail++; $display("FAIL mr_abort: got %h/%h exp 0/0", HTRANS, HADDR); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mr_cmd_ready: got %b exp 1", cmd_ready); end
        repeat (2) @(negedge HCLK);
        n_checks++; if (rd_valid !== 1'b0 || rd_n !== 0) begin n_fail++; $display("FAIL mr_no_read: got %b/%0d exp 0/0", rd_valid, rd_n); end
        HRESETn = 1'b1;
        @(negedge HCLK);
        n_checks++; if (rd_n !== 0 || acc_n !== 1) begin n_fail++; $display("FAIL mr_after: got %0d/%0d exp 0/1", rd_n, acc_n); end
        send_cmd(1'b0, 32'h8000_0100, 4'd0);
        wait_idle();
        n_checks++; if (rd_n !== 1 || rd_d[0] !== 32'hDA5A_0100 || rd_l[0] !== 1'b1) begin n_fail++; $display("FAIL mr_new_cmd: got %0d/%h/%b exp 1/da5a0100/1", rd_n, rd_d[0], rd_l[0]); end
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_en = 1'b0; wr_tot = 0; clr = 1'b1;
        for (int i = 0; i < 4; i++) wdat[i] = '0;
        @(negedge HCLK);
        clr = 1'b0;
        test_reset();
        test_single_write();
        test_incr_read();
        test_boundary();
        test_hready_stall();
        test_busy();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
